vga_pixel_renderer: RTL and testbench

Downstream of the game top level, this block turns the VGA tracker's pixel position and the game state into registered 24-bit RGB for the DAC. It maps each pixel to a game cell and colours it by layer priority: overlay digits, border, head, body, fruit, background. It also carries an IDLE/PLAY/OVER display FSM whose changes are committed only at frame boundaries. The same pipeline delays the tracker's sync pulses so they stay aligned with the colour data.

---
 rtl/vga_pixel_renderer.sv | 192 +++++++++++++++++++
 tb/tb_vga_pixel_renderer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_renderer.sv
// Two-stage VGA colour pipeline: pixel -> game cell -> layered RGB, with syncs delayed to match.
// Optional build macro RENDER_BLINK_EN adds the game-over head/body blink counter.
module vga_pixel_renderer #(
  parameter int CELL_SHIFT   = 3,
  parameter int BLINK_FRAMES = 15,
  parameter int COLS         = 80,
  parameter int ROWS         = 60
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic [9:0] X,
  input  logic [9:0] Y,
  input  logic       display_area,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       frame_tik,
  input  logic [6:0] snake_head_x,
  input  logic [6:0] snake_head_y,
  input  logic [6:0] fruit_x,
  input  logic [6:0] fruit_y,
  input  logic       body_hit,
  input  logic       number_pixel,
  input  logic       start,
  input  logic       game_over,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [23:0] RGB_BLACK  = 24'h000000;
  localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] RGB_GREY   = 24'h808080;
  localparam logic [23:0] RGB_YELLOW = 24'hFFFF00;
  localparam logic [23:0] RGB_GREEN  = 24'h00C000;
  localparam logic [23:0] RGB_RED    = 24'hFF0000;
  localparam logic [23:0] RGB_BG     = 24'h101030;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);

  // The blink counter is 5 bits wide, so the half-period must fit in it.
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 32) begin : g_bad_blink_frames
    $error("BLINK_FRAMES must be in 1..32");
  end

  state_e state_q;

  logic [6:0] cell_x_s;
  logic [6:0] cell_y_s;
  logic       head_eq_d, fruit_eq_d, border_d;
  logic       head_eq_q, fruit_eq_q, border_q;
  logic       de1_q, hs1_q, vs1_q;

  logic [23:0] rgb_d;
  logic [23:0] rgb_q;
  logic        hs2_q, vs2_q, blank_q;

  logic        not_idle_s;
  logic        blink_red_s;

  assign cell_x_s = 7'(X >> CELL_SHIFT);
  assign cell_y_s = 7'(Y >> CELL_SHIFT);

  always_comb begin
    head_eq_d  = (cell_x_s == snake_head_x) && (cell_y_s == snake_head_y);
    fruit_eq_d = (cell_x_s == fruit_x) && (cell_y_s == fruit_y);
    border_d   = (cell_x_s == 7'd0) || (cell_x_s == LAST_COL) ||
                 (cell_y_s == 7'd0) || (cell_y_s == LAST_ROW);
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      head_eq_q  <= 1'b0;
      fruit_eq_q <= 1'b0;
      border_q   <= 1'b0;
      de1_q      <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
    end else begin
      head_eq_q  <= head_eq_d;
      fruit_eq_q <= fruit_eq_d;
      border_q   <= border_d;
      de1_q      <= display_area;
      hs1_q      <= h_sync_in;
      vs1_q      <= v_sync_in;
    end
  end

  // Display state only moves on a frame tick, so a visible frame never mixes states.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (frame_tik) begin
      case (state_q)
        ST_IDLE: state_q <= start ? ST_PLAY : ST_IDLE;
        ST_PLAY: state_q <= game_over ? ST_OVER : ST_PLAY;
        ST_OVER: state_q <= (!start && !game_over) ? ST_IDLE : ST_OVER;
        default: state_q <= ST_IDLE;
      endcase
    end else begin
      state_q <= state_q;
    end
  end

`ifdef RENDER_BLINK_EN
  localparam logic [4:0] BLINK_LAST = 5'(BLINK_FRAMES - 1);

  logic [4:0] blink_cnt_q;
  logic       blink_phase_q;

  // Counts only while OVER persists across a tick; any other tick (entry, exit, IDLE, PLAY) clears it.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      blink_cnt_q   <= 5'd0;
      blink_phase_q <= 1'b0;
    end else if (frame_tik) begin
      if ((state_q == ST_OVER) && (start || game_over)) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q   <= 5'd0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q   <= blink_cnt_q + 5'd1;
          blink_phase_q <= blink_phase_q;
        end
      end else begin
        blink_cnt_q   <= 5'd0;
        blink_phase_q <= 1'b0;
      end
    end else begin
      blink_cnt_q   <= blink_cnt_q;
      blink_phase_q <= blink_phase_q;
    end
  end

  assign blink_red_s = (state_q == ST_OVER) && blink_phase_q;
`else
  assign blink_red_s = (state_q == ST_OVER);
`endif

  assign not_idle_s = (state_q != ST_IDLE);

  // body_hit and number_pixel arrive one cycle after X/Y, so they meet the stage-1 flags here.
  always_comb begin
    rgb_d = RGB_BG;
    if (!de1_q) begin
      rgb_d = RGB_BLACK;
    end else if (number_pixel) begin
      rgb_d = RGB_WHITE;
    end else if (border_q) begin
      rgb_d = RGB_GREY;
    end else if (head_eq_q && not_idle_s) begin
      rgb_d = blink_red_s ? RGB_RED : RGB_YELLOW;
    end else if (body_hit && not_idle_s) begin
      rgb_d = blink_red_s ? RGB_RED : RGB_GREEN;
    end else if (fruit_eq_q && (state_q == ST_PLAY)) begin
      rgb_d = RGB_RED;
    end else begin
      rgb_d = RGB_BG;
    end
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      rgb_q   <= 24'h000000;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      blank_q <= de1_q;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_N = blank_q;

endmodule

// File: tb/tb_vga_pixel_renderer.sv
// Directed bench for vga_pixel_renderer: vector table for colour priority plus sequences for
// reset, sync alignment, frame-boundary commit, game-over colouring and OVER->IDLE.
module tb_vga_pixel_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] X, Y;
  logic       display_area, h_sync_in, v_sync_in, frame_tik;
  logic [6:0] snake_head_x, snake_head_y, fruit_x, fruit_y;
  logic       body_hit, number_pixel, start, game_over;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N;

  int errors = 0;
  int checks = 0;

  vga_pixel_renderer dut (
    .clock_25(clk), .reset(reset), .X(X), .Y(Y), .display_area(display_area),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .frame_tik(frame_tik),
    .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .body_hit(body_hit),
    .number_pixel(number_pixel), .start(start), .game_over(game_over),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          ph;
    logic [9:0]  x, y;
    logic [6:0]  hx, hy, fx, fy;
    logic        de, bh, np;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic chk_out(input string name, input logic [23:0] rgb, input logic hs, vs, blank);
    chk({name, "_rgb"}, {VGA_R, VGA_G, VGA_B}, rgb);
    chk({name, "_hs"}, VGA_HS, hs);
    chk({name, "_vs"}, VGA_VS, vs);
    chk({name, "_blank"}, VGA_BLANK_N, blank);
  endtask

  // X/Y in one cycle, body/number in the next, outputs read after the second edge.
  task automatic pix(input logic [9:0] x, y, input logic de, bh, np,
                     output logic [23:0] rgb, output logic blank);
    @(negedge clk);
    X = x; Y = y; display_area = de;
    @(negedge clk);
    X = 10'd0; Y = 10'd0; display_area = 1'b0; body_hit = bh; number_pixel = np;
    @(negedge clk);
    body_hit = 1'b0; number_pixel = 1'b0;
    rgb = {VGA_R, VGA_G, VGA_B};
    blank = VGA_BLANK_N;
  endtask

  task automatic pix_chk(input string name, input logic [9:0] x, y, input logic bh,
                         input logic [23:0] expv);
    logic [23:0] rgb;
    logic        blank;
    pix(x, y, 1'b1, bh, 1'b0, rgb, blank);
    chk(name, rgb, expv);
  endtask

  task automatic tik();
    @(negedge clk);
    frame_tik = 1'b1;
    @(negedge clk);
    frame_tik = 1'b0;
  endtask

  task automatic run_rows(input int ph);
    logic [23:0] rgb;
    logic        blank;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].ph == ph) begin
        snake_head_x = vecs[i].hx; snake_head_y = vecs[i].hy;
        fruit_x = vecs[i].fx;      fruit_y = vecs[i].fy;
        pix(vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].bh, vecs[i].np, rgb, blank);
        chk($sformatf("vec%0d_rgb", i), rgb, vecs[i].exp);
        chk($sformatf("vec%0d_blank", i), blank, vecs[i].de);
      end
    end
  endtask

  // k = frame ticks since entering OVER; blink half-period is 15 frames.
  function automatic logic [23:0] over_col(input int k, input logic [23:0] normal);
`ifdef RENDER_BLINK_EN
    return (((k / 15) % 2) == 1) ? 24'hFF0000 : normal;
`else
    return (k >= 0) ? 24'hFF0000 : normal;
`endif
  endfunction

  initial begin
    // phase 0: IDLE, phase 1: PLAY
    vecs[0]  = '{0, 10'd80,  10'd80,  7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 1'b1, 1'b0, 24'h101030};
    vecs[1]  = '{0, 10'd0,   10'd80,  7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 1'b0, 1'b0, 24'h808080};
    vecs[2]  = '{0, 10'd639, 10'd200, 7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 1'b0, 1'b0, 24'h808080};
    vecs[3]  = '{0, 10'd200, 10'd479, 7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 1'b0, 1'b0, 24'h808080};
    vecs[4]  = '{0, 10'd80,  10'd80,  7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 1'b0, 1'b1, 24'hFFFFFF};
    vecs[5]  = '{0, 10'd80,  10'd80,  7'd10, 7'd10, 7'd10, 7'd10, 1'b0, 1'b0, 1'b1, 24'h000000};
    vecs[6]  = '{0, 10'd8,   10'd8,   7'd1,  7'd1,  7'd1,  7'd1,  1'b1, 1'b1, 1'b0, 24'h101030};
    vecs[7]  = '{1, 10'd80,  10'd80,  7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 1'b1, 1'b0, 24'hFFFF00};
    vecs[8]  = '{1, 10'd80,  10'd80,  7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    vecs[9]  = '{1, 10'd80,  10'd80,  7'd11, 7'd10, 7'd10, 7'd10, 1'b1, 1'b1, 1'b0, 24'h00C000};
    vecs[10] = '{1, 10'd80,  10'd80,  7'd11, 7'd10, 7'd10, 7'd10, 1'b1, 1'b0, 1'b0, 24'hFF0000};
    vecs[11] = '{1, 10'd87,  10'd87,  7'd10, 7'd10, 7'd20, 7'd20, 1'b1, 1'b0, 1'b0, 24'hFFFF00};
    vecs[12] = '{1, 10'd88,  10'd80,  7'd10, 7'd10, 7'd20, 7'd20, 1'b1, 1'b0, 1'b0, 24'h101030};
    vecs[13] = '{1, 10'd0,   10'd40,  7'd0,  7'd5,  7'd0,  7'd5,  1'b1, 1'b1, 1'b0, 24'h808080};
    vecs[14] = '{1, 10'd632, 10'd472, 7'd79, 7'd59, 7'd20, 7'd20, 1'b1, 1'b0, 1'b0, 24'h808080};
    vecs[15] = '{1, 10'd80,  10'd80,  7'd10, 7'd10, 7'd10, 7'd10, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[16] = '{1, 10'd8,   10'd8,   7'd40, 7'd40, 7'd1,  7'd1,  1'b1, 1'b0, 1'b0, 24'hFF0000};

    // Active inputs during reset show the flush really holds the outputs.
    reset = 1'b1; X = 10'd0; Y = 10'd0; display_area = 1'b1;
    h_sync_in = 1'b0; v_sync_in = 1'b0; frame_tik = 1'b0;
    snake_head_x = 7'd10; snake_head_y = 7'd10; fruit_x = 7'd20; fruit_y = 7'd20;
    body_hit = 1'b0; number_pixel = 1'b0; start = 1'b0; game_over = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out($sformatf("reset%0d", i), 24'h000000, 1'b1, 1'b1, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk_out("release1", 24'h000000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("release2", 24'h808080, 1'b0, 1'b0, 1'b1);
    display_area = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
    repeat (3) @(negedge clk);

    // HS low one cycle, VS low the next: each must appear exactly two cycles on.
    X = 10'd0; Y = 10'd0; display_area = 1'b1; h_sync_in = 1'b0;
    @(negedge clk);
    display_area = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b0;
    chk_out("sync_t1", 24'h000000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    v_sync_in = 1'b1;
    chk_out("sync_t2", 24'h808080, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_out("sync_t3", 24'h000000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("sync_t4", 24'h000000, 1'b1, 1'b1, 1'b0);

    run_rows(0);

    // A start pulse that is gone by the tick must not leave IDLE.
    snake_head_x = 7'd10; snake_head_y = 7'd10; fruit_x = 7'd20; fruit_y = 7'd20;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tik();
    pix_chk("nolatch_fruit", 10'd160, 10'd160, 1'b0, 24'h101030);
    pix_chk("nolatch_head", 10'd80, 10'd80, 1'b0, 24'h101030);

    start = 1'b1;
    pix_chk("commit_pre_fruit", 10'd160, 10'd160, 1'b0, 24'h101030);
    pix_chk("commit_pre_head", 10'd80, 10'd80, 1'b0, 24'h101030);
    tik();
    pix_chk("commit_post_fruit", 10'd160, 10'd160, 1'b0, 24'hFF0000);

    run_rows(1);

    snake_head_x = 7'd10; snake_head_y = 7'd10; fruit_x = 7'd20; fruit_y = 7'd20;
    game_over = 1'b1;
    pix_chk("over_pre_head", 10'd80, 10'd80, 1'b0, 24'hFFFF00);
    tik();
    pix_chk("over_fruit", 10'd160, 10'd160, 1'b0, 24'h101030);
`ifdef RENDER_BLINK_EN
    for (int k = 0; k < 45; k++) begin
`else
    for (int k = 0; k < 5; k++) begin
`endif
      pix_chk($sformatf("over_head_f%0d", k), 10'd80, 10'd80, 1'b0, over_col(k, 24'hFFFF00));
      pix_chk($sformatf("over_body_f%0d", k), 10'd400, 10'd400, 1'b1, over_col(k, 24'h00C000));
      if (k < 44) tik();
    end
    tik();

    // Deassertion mid-frame keeps OVER until the tick.
    start = 1'b0; game_over = 1'b0;
`ifdef RENDER_BLINK_EN
    pix_chk("exit_pre_head", 10'd80, 10'd80, 1'b0, over_col(45, 24'hFFFF00));
`else
    pix_chk("exit_pre_head", 10'd80, 10'd80, 1'b0, over_col(5, 24'hFFFF00));
`endif
    tik();
    pix_chk("idle_head", 10'd80, 10'd80, 1'b0, 24'h101030);
    pix_chk("idle_body", 10'd400, 10'd400, 1'b1, 24'h101030);
    pix_chk("idle_border", 10'd0, 10'd240, 1'b0, 24'h808080);

    // start and game_over together in IDLE go to PLAY, then OVER on the following tick.
    start = 1'b1; game_over = 1'b1;
    tik();
    pix_chk("both_play_head", 10'd80, 10'd80, 1'b0, 24'hFFFF00);
    pix_chk("both_play_fruit", 10'd160, 10'd160, 1'b0, 24'hFF0000);
    tik();
    pix_chk("both_over_head", 10'd80, 10'd80, 1'b0, over_col(0, 24'hFFFF00));
    pix_chk("both_over_fruit", 10'd160, 10'd160, 1'b0, 24'h101030);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
